uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width default,
// arbiter state type and the round-robin winner search.
package uart_pkg;

  localparam int DATA_WIDTH_C = 8;
  localparam int MAX_REQ_C    = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  // Index of the first set request after last_idx, wrapping; 0 when none set.
  function automatic int rr_pick_f(input logic [MAX_REQ_C-1:0] req_vec,
                                   input int last_idx,
                                   input int num_req);
    int   win_v;
    int   idx_v;
    logic found_v;
    win_v   = 0;
    found_v = 1'b0;
    for (int i = 1; i <= MAX_REQ_C; i++) begin
      idx_v = (last_idx + i) % num_req;
      if ((i <= num_req) && !found_v && req_vec[idx_v[2:0]]) begin
        win_v   = idx_v;
        found_v = 1'b1;
      end
    end
    return win_v;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin rotator: request vector plus last owner in,
// one-hot winner and its index out.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ_P = 4,
  parameter int IDX_W_P   = 2
) (
  input  logic [NUM_REQ_P-1:0] req_vec,
  input  logic [IDX_W_P-1:0]   last_grant,
  output logic [NUM_REQ_P-1:0] grant_vec,
  output logic [IDX_W_P-1:0]   grant_idx
);

  logic [MAX_REQ_C-1:0] req_pad_s;
  int                   win_s;

  // Rotate priority so the requester after last_grant is searched first.
  always_comb begin
    req_pad_s                  = '0;
    req_pad_s[NUM_REQ_P-1:0]   = req_vec;
    win_s                      = rr_pick_f(req_pad_s, int'(last_grant), NUM_REQ_P);
    grant_idx                  = IDX_W_P'(win_s);
    grant_vec                  = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      grant_vec[k] = (|req_vec) && (win_s == k);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding several byte streams into one
// uart_tx, with an idle timeout that abandons a stalled owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ_P    = 4,
  parameter int DATA_WIDTH_P = DATA_WIDTH_C,
  parameter int TIMEOUT_P    = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0] req_tdata_i,
  input  logic [NUM_REQ_P-1:0]              req_tvalid_i,
  input  logic [NUM_REQ_P-1:0]              req_tlast_i,
  output logic [NUM_REQ_P-1:0]              req_tready_o,
  output logic [DATA_WIDTH_P-1:0]           m_tdata_o,
  output logic                              m_tvalid_o,
  input  logic                              m_tready_i,
  output logic [NUM_REQ_P-1:0]              grant_o,
  output logic                              busy_o,
  output logic                              abort_o
);

  localparam int IDX_W_C = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;
  localparam int CNT_W_C = $clog2(TIMEOUT_P + 1);

  arb_state_e           state_r, state_s;
  logic [NUM_REQ_P-1:0] grant_r, grant_s;
  logic [IDX_W_C-1:0]   gidx_r, gidx_s;
  logic [IDX_W_C-1:0]   last_r, last_s;
  logic [CNT_W_C-1:0]   cnt_r, cnt_s;
  logic                 abort_r, abort_s;

  logic [NUM_REQ_P-1:0] pick_vec_s;
  logic [IDX_W_C-1:0]   pick_idx_s;
  logic                 send_s, g_valid_s, g_last_s, hs_s;

  rr_pick #(
    .NUM_REQ_P (NUM_REQ_P),
    .IDX_W_P   (IDX_W_C)
  ) u_rr_pick (
    .req_vec    (req_tvalid_i),
    .last_grant (last_r),
    .grant_vec  (pick_vec_s),
    .grant_idx  (pick_idx_s)
  );

  assign send_s    = (state_r == ST_SEND);
  assign g_valid_s = req_tvalid_i[gidx_r];
  assign g_last_s  = req_tlast_i[gidx_r];
  assign hs_s      = send_s & g_valid_s & m_tready_i;

  // Datapath: only the owner is mirrored to uart_tx, and only while sending.
  always_comb begin
    m_tvalid_o   = 1'b0;
    m_tdata_o    = '0;
    req_tready_o = '0;
    if (send_s) begin
      m_tvalid_o   = g_valid_s;
      m_tdata_o    = req_tdata_i[gidx_r*DATA_WIDTH_P +: DATA_WIDTH_P];
      req_tready_o = grant_r & {NUM_REQ_P{m_tready_i}};
    end else begin
      m_tvalid_o = 1'b0;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until tlast or timeout.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    gidx_s  = gidx_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    abort_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_tvalid_i) begin
          grant_s = pick_vec_s;
          gidx_s  = pick_idx_s;
          cnt_s   = '0;
          state_s = ST_SEND;
        end else begin
          grant_s = '0;
        end
      end
      ST_SEND: begin
        if (hs_s && g_last_s) begin
          last_s  = gidx_r;
          grant_s = '0;
          cnt_s   = '0;
          state_s = ST_IDLE;
        end else if (hs_s) begin
          cnt_s = '0;
        end else if (!g_valid_s && m_tready_i) begin
          // A busy uart_tx must not count against the owner.
          if (cnt_r == CNT_W_C'(TIMEOUT_P - 1)) begin
            abort_s = 1'b1;
            last_s  = gidx_r;
            grant_s = '0;
            cnt_s   = '0;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W_C'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State registers; reset abandons any packet and restores requester 0 priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      last_r  <= IDX_W_C'(NUM_REQ_P - 1);
      cnt_r   <= '0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      gidx_r  <= gidx_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      abort_r <= abort_s;
    end
  end

  assign grant_o = grant_r;
  assign busy_o  = send_s;
  assign abort_o = abort_r;

endmodule
